mmu_feeder: RTL and testbench

Operand staging and skew unit driving the 4x4 systolic matrix-multiply array. It accepts a tile of up to `max_k` data/weight vector pairs over a valid/ready input. It buffers the tile, then replays it with a diagonal skew so that lane *i* lags lane 0 by *i* cycles, which is what the array's `data_arr`/`wt_arr` inputs require. A drain phase and a `done` pulse follow, so the downstream result collector knows when the array's `acc_out` is final.

---
 rtl/mmu_feeder.sv | 157 +++++++++++++++
 tb/tb_mmu_feeder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_feeder.sv
// Operand staging/skew feeder for the depth x depth systolic array; optional busy-cycle counter under MMU_FEEDER_PERF_CNT_EN.
// Latency: step 0 appears 2 cycles after the last input beat; done pulses k_eff+2*depth+1 cycles after it.
// Backpressure: in_ready is high only in LOAD; beats are never stalled by the feeder, only by in_valid gaps.
module mmu_feeder #(
  parameter int depth     = 4,
  parameter int bit_width = 8,
  parameter int max_k     = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(max_k+1)-1:0]     k_len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [bit_width*depth-1:0]     in_data,
  input  logic [bit_width*depth-1:0]     in_wt,
  output logic [bit_width*depth-1:0]     data_arr,
  output logic [bit_width*depth-1:0]     wt_arr,
  output logic                           control,
  output logic                           busy,
`ifdef MMU_FEEDER_PERF_CNT_EN
  output logic                           done,
  output logic [31:0]                    busy_cycles
`else
  output logic                           done
`endif
);

  localparam int KW = $clog2(max_k + 1);
  localparam int TW = $clog2(max_k + depth);
  localparam int DW = $clog2(depth + 1);
  localparam int PW = (max_k > 1) ? $clog2(max_k) : 1;
  localparam int VW = bit_width * depth;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  state_t          state;
  logic [KW-1:0]   k_eff;
  logic [KW-1:0]   wr_cnt;
  logic [TW-1:0]   step;
  logic [DW-1:0]   drain_cnt;
  logic [KW-1:0]   k_clamped;
  logic [TW-1:0]   last_step;
  logic [VW-1:0]   skew_data;
  logic [VW-1:0]   skew_wt;
  logic [VW-1:0]   buf_data [max_k];
  logic [VW-1:0]   buf_wt   [max_k];
  logic            beat;

  assign k_clamped = (k_len > KW'(max_k)) ? KW'(max_k) : k_len;
  assign last_step = TW'(k_eff) + TW'(depth - 2);
  assign beat      = (state == LOAD) && in_valid && in_ready;

  // Tile buffer: contents need no reset, every entry read is written earlier in the same tile
  always_ff @(posedge clk) begin
    if (beat) begin
      buf_data[wr_cnt[PW-1:0]] <= in_data;
      buf_wt[wr_cnt[PW-1:0]]   <= in_wt;
    end
  end

  // Diagonal skew: lane i shows entry (step - i) when that entry exists, zero otherwise
  always_comb begin
    int idx;
    idx       = 0;
    skew_data = '0;
    skew_wt   = '0;
    for (int i = 0; i < depth; i++) begin
      idx = int'(step) - i;
      if (idx >= 0 && idx < int'(k_eff)) begin
        skew_data[i*bit_width +: bit_width] = buf_data[idx[PW-1:0]][i*bit_width +: bit_width];
        skew_wt[i*bit_width +: bit_width]   = buf_wt[idx[PW-1:0]][i*bit_width +: bit_width];
      end
    end
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k_eff     <= '0;
      wr_cnt    <= '0;
      step      <= '0;
      drain_cnt <= '0;
      data_arr  <= '0;
      wt_arr    <= '0;
      control   <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_eff  <= k_clamped;
            wr_cnt <= '0;
            if (k_clamped == '0) begin
              done <= 1'b1;
            end else begin
              state    <= LOAD;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            wr_cnt <= wr_cnt + KW'(1);
            if ((wr_cnt + KW'(1)) == k_eff) begin
              state    <= STREAM;
              in_ready <= 1'b0;
              step     <= '0;
            end
          end
        end
        STREAM: begin
          data_arr <= skew_data;
          wt_arr   <= skew_wt;
          control  <= 1'b1;
          step     <= step + TW'(1);
          if (step == last_step) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          data_arr <= '0;
          wt_arr   <= '0;
          // depth zero vectors flush the array, then one cycle announces completion
          if (drain_cnt == DW'(depth)) begin
            control <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            control   <= 1'b1;
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MMU_FEEDER_PERF_CNT_EN
  // Saturating count of cycles with busy asserted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cycles <= '0;
    end else if (busy && (busy_cycles != 32'hFFFF_FFFF)) begin
      busy_cycles <= busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mmu_feeder.sv
// Scoreboard bench for mmu_feeder: driver pushes expected skewed vectors/done with their due cycle,
// a negedge monitor pops and compares whenever control or done is high.
// Covers reset, minimal/full tiles, stalls, clamp, zero length, ignored start, mid-stream reset.
module tb_mmu_feeder;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  k_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_wt;
  logic [31:0] data_arr;
  logic [31:0] wt_arr;
  logic        control;
  logic        busy;
  logic        done;
`ifdef MMU_FEEDER_PERF_CNT_EN
  logic [31:0] busy_cycles;
`endif

  typedef struct {
    logic [31:0] d;
    logic [31:0] w;
    bit          is_done;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc;
  int          n_checks;
  int          n_fail;
  logic [31:0] bd [8];
  logic [31:0] bw [8];
  logic [31:0] hd [4];
  logic [31:0] hw [4];

  mmu_feeder #(.depth(4), .bit_width(8), .max_k(8)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_wt(in_wt),
    .data_arr(data_arr), .wt_arr(wt_arr), .control(control), .busy(busy),
`ifdef MMU_FEEDER_PERF_CNT_EN
    .done(done), .busy_cycles(busy_cycles)
`else
    .done(done)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every presented array vector or done pulse must match the head of the queue
  always @(negedge clk) begin
    if (reset && (control || done)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output cyc=%0d control=%b done=%b data=%h wt=%h",
                 cyc, control, done, data_arr, wt_arr);
      end else begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if (data_arr !== mon_e.d || wt_arr !== mon_e.w || done !== mon_e.is_done ||
            control !== !mon_e.is_done || cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL stream_vec cyc=%0d (want %0d) data=%h (want %h) wt=%h (want %h) done=%b (want %b) control=%b",
                   cyc, mon_e.cyc, data_arr, mon_e.d, wt_arr, mon_e.w, done, mon_e.is_done, control);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] skew_vec(input bit use_wt, input int k, input int t);
    logic [31:0] r;
    logic [31:0] src;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (t - i >= 0 && t - i < k) begin
        src = use_wt ? bw[t-i] : bd[t-i];
        r[i*8 +: 8] = src[i*8 +: 8];
      end
    end
    return r;
  endfunction

  // Expected stream for a tile whose last beat is at cycle L; stop_step>=0 truncates before that step
  task automatic push_expect(input int L, input int k, input int stop_step, input bit hand);
    exp_t e;
    int nsteps;
    nsteps = (stop_step >= 0) ? stop_step : k + 3;
    for (int t = 0; t < nsteps; t++) begin
      e.d = hand ? hd[t] : skew_vec(1'b0, k, t);
      e.w = hand ? hw[t] : skew_vec(1'b1, k, t);
      e.is_done = 1'b0;
      e.cyc = L + 2 + t;
      exp_q.push_back(e);
    end
    if (stop_step < 0) begin
      for (int j = 0; j < 4; j++) begin
        e.d = '0; e.w = '0; e.is_done = 1'b0; e.cyc = L + 1 + k + 4 + j;
        exp_q.push_back(e);
      end
      e.d = '0; e.w = '0; e.is_done = 1'b1; e.cyc = L + 1 + k + 8;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_tile(input int klen, input bit stall, input bit ign_start,
                          input int rst_step, input bit hand);
    int   keff;
    int   L;
    int   c;
    bit   seen;
    exp_t e;
    keff = (klen > 8) ? 8 : klen;
    L    = 0;
    @(posedge clk); #1;
    start = 1'b1;
    k_len = 4'(klen);
    c = cyc;
    if (keff == 0) begin
      e.d = '0; e.w = '0; e.is_done = 1'b1; e.cyc = c + 1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (keff == 0) begin
      check("zero_len_busy", {31'd0, busy}, 32'd0);
      check("zero_len_in_ready", {31'd0, in_ready}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("zero_len_queue_left", exp_q.size(), 0);
      exp_q.delete();
      return;
    end
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_in_ready", {31'd0, in_ready}, 32'd1);
    for (int b = 0; b < keff; b++) begin
      in_valid = 1'b1;
      in_data  = bd[b];
      in_wt    = bw[b];
      if (b == keff - 1) begin
        L = cyc;
        push_expect(L, keff, rst_step, hand);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
      in_wt    = '0;
      if (stall && b != keff - 1) begin
        @(posedge clk); #1;
      end
    end
    check("in_ready_drop", {31'd0, in_ready}, 32'd0);
    if (rst_step >= 0) begin
      repeat (rst_step + 1) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rst_data_arr", data_arr, 32'd0);
      check("rst_wt_arr", wt_arr, 32'd0);
      check("rst_control", {31'd0, control}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_queue_left", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      return;
    end
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(posedge clk); #1;
      if (ign_start) begin
        start = (cyc == L + 3);
        k_len = 4'd2;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout cyc=%0d", cyc);
    end else begin
      check("done_busy", {31'd0, busy}, 32'd0);
    end
    @(negedge clk); #1;
    check("queue_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_minimal;
    bd[0] = 32'h04030201;
    bw[0] = 32'h08070605;
    hd[0] = 32'h00000001; hw[0] = 32'h00000005;
    hd[1] = 32'h00000200; hw[1] = 32'h00000600;
    hd[2] = 32'h00030000; hw[2] = 32'h00070000;
    hd[3] = 32'h04000000; hw[3] = 32'h08000000;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
`ifdef MMU_FEEDER_PERF_CNT_EN
    logic [31:0] pc0;
`endif
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    in_data  = '0;
    in_wt    = '0;
    #3 reset = 1'b0;
    #5;
    check("reset_data_arr", data_arr, 32'd0);
    check("reset_wt_arr", wt_arr, 32'd0);
    check("reset_control", {31'd0, control}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    #14 reset = 1'b1;

    // Minimal tile with hand-computed skew
    load_minimal();
`ifdef MMU_FEEDER_PERF_CNT_EN
    pc0 = busy_cycles;
`endif
    run_tile(1, 1'b0, 1'b0, -1, 1'b1);
`ifdef MMU_FEEDER_PERF_CNT_EN
    check("busy_cycles_delta", busy_cycles - pc0, 32'd10);
`endif

    // Full tile: element = 16*beat + lane for data, xor A5 for weights
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 4; i++) begin
        bd[b][i*8 +: 8] = 8'(16 * b + i);
        bw[b][i*8 +: 8] = 8'(16 * b + i) ^ 8'hA5;
      end
    end
    run_tile(8, 1'b0, 1'b0, -1, 1'b0);
    run_tile(8, 1'b1, 1'b0, -1, 1'b0);
    run_tile(15, 1'b0, 1'b0, -1, 1'b0);

    // Zero length, then start ignored during STREAM
    run_tile(0, 1'b0, 1'b0, -1, 1'b0);
    run_tile(4, 1'b0, 1'b1, -1, 1'b0);

    // Reset while step 2 is presented, then a clean minimal tile
    run_tile(4, 1'b0, 1'b0, 2, 1'b0);
    load_minimal();
    run_tile(1, 1'b0, 1'b0, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
